// File: rtl/arb_pkg.sv
// Shared types and helpers for the priority arbiter.
// Holds the FSM state type, default sizing and the round-robin pointer step.
package arb_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    localparam int DEF_N        = 8;
    localparam int DEF_MAX_HOLD = 16;

    // After a round-robin grant to w, the search restarts just below w, wrapping to n-1.
    function automatic int unsigned ptr_after(input int unsigned w, input int unsigned n);
        return (w == 0) ? n - 1 : w - 1;
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational priority encoder: the highest set bit of vec wins.
// found is low and idx is 0 when vec is all-zero.
module prio_pick #(
    parameter int N    = 8,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    vec,
    output logic            found,
    output logic [ID_W-1:0] idx
);

    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                found = 1'b1;
                idx   = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/prio_arbiter.sv
// Registered N-way arbiter with fixed or round-robin priority and a hold budget.
// A grant is held until release, followed by one dead cycle before the next grant.
module prio_arbiter
    import arb_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int ID_W     = $clog2(N),
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            rr_en,
    input  logic            done,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_vld,
    output logic            timeout
);

    localparam int                CNT_W    = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0]  HOLD_MAX = CNT_W'(MAX_HOLD);

    state_t            state, state_nxt;
    logic [ID_W-1:0]   ptr, ptr_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [N-1:0]      gnt_nxt;
    logic [ID_W-1:0]   id_nxt;
    logic              vld_nxt;
    logic              to_nxt;

    logic [N-1:0]      mask;
    logic [N-1:0]      masked_req;
    logic              m_found, u_found;
    logic [ID_W-1:0]   m_idx, u_idx;
    logic [ID_W-1:0]   win;

    logic              drop;
    logic              hold_hit;
    logic              release_now;

    // Round-robin searches bits at or below ptr first; an empty window falls back to the full vector.
    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i <= int'(ptr));
        end
    end

    assign masked_req = req & mask;

    prio_pick #(.N(N), .ID_W(ID_W)) u_pick_masked (
        .vec   (masked_req),
        .found (m_found),
        .idx   (m_idx)
    );

    prio_pick #(.N(N), .ID_W(ID_W)) u_pick_full (
        .vec   (req),
        .found (u_found),
        .idx   (u_idx)
    );

    assign win = (rr_en && m_found) ? m_idx : u_idx;

    assign drop        = !req[gnt_id];
    assign hold_hit    = (MAX_HOLD != 0) && (cnt == HOLD_MAX);
    assign release_now = drop || done || hold_hit;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt;
        id_nxt    = gnt_id;
        vld_nxt   = gnt_vld;
        to_nxt    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (u_found) begin
                    state_nxt    = ST_GRANT;
                    gnt_nxt      = '0;
                    gnt_nxt[win] = 1'b1;
                    id_nxt       = win;
                    vld_nxt      = 1'b1;
                    cnt_nxt      = CNT_W'(1);
                    if (rr_en) begin
                        ptr_nxt = ID_W'(ptr_after(32'(win), N));
                    end
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    state_nxt = ST_IDLE;
                    gnt_nxt   = '0;
                    id_nxt    = '0;
                    vld_nxt   = 1'b0;
                    // A timeout is reported only when the budget alone ended the grant.
                    to_nxt    = hold_hit && !drop && !done;
                end else if (MAX_HOLD != 0 && cnt != HOLD_MAX) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= ID_W'(N - 1);
            cnt     <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            gnt_vld <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            cnt     <= cnt_nxt;
            gnt     <= gnt_nxt;
            gnt_id  <= id_nxt;
            gnt_vld <= vld_nxt;
            timeout <= to_nxt;
        end
    end

endmodule

// File: tb/tb_prio_arbiter.sv
// Self-checking bench for prio_arbiter: directed scenarios plus random traffic,
// compared every cycle against a behavioural model of the arbitration rules.
module tb_prio_arbiter;

    localparam int N        = 8;
    localparam int ID_W     = 3;
    localparam int MAX_HOLD = 4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic            rr_en;
    logic            done;
    logic [N-1:0]    gnt;
    logic [ID_W-1:0] gnt_id;
    logic            gnt_vld;
    logic            timeout;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit m_busy;
    int m_owner;
    int m_held;
    int m_ptr;
    logic [N-1:0]    e_gnt;
    logic [ID_W-1:0] e_id;
    logic            e_vld;
    logic            e_to;

    prio_arbiter #(.N(N), .ID_W(ID_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .rr_en   (rr_en),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Winner by rule: fixed = highest requesting index; rr = first requester walking down from ptr with wrap.
    function automatic int pick_winner(input logic [N-1:0] r, input bit rr, input int p);
        if (rr) begin
            for (int k = 0; k < N; k++) begin
                if (r[(p - k + N) % N]) return (p - k + N) % N;
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (r[i]) return i;
            end
        end
        return 0;
    endfunction

    task automatic model_step();
        e_to = 1'b0;
        if (rst) begin
            m_busy = 0; m_owner = 0; m_held = 0; m_ptr = N - 1;
        end else if (!m_busy) begin
            if (req != '0) begin
                m_owner = pick_winner(req, rr_en, m_ptr);
                m_busy  = 1;
                m_held  = 1;
                if (rr_en) m_ptr = (m_owner == 0) ? N - 1 : m_owner - 1;
            end
        end else begin
            bit dropped, expired;
            dropped = !req[m_owner];
            expired = (MAX_HOLD != 0) && (m_held >= MAX_HOLD);
            if (dropped || done || expired) begin
                m_busy = 0;
                e_to   = expired && !dropped && !done;
            end else begin
                m_held++;
            end
        end
        e_vld = m_busy;
        e_gnt = m_busy ? (N'(1) << m_owner) : '0;
        e_id  = m_busy ? ID_W'(m_owner) : '0;
    endtask

    // Advance one clock with the inputs currently applied, then compare all outputs.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("gnt",     32'(gnt),     32'(e_gnt));
        check("gnt_id",  32'(gnt_id),  32'(e_id));
        check("gnt_vld", 32'(gnt_vld), 32'(e_vld));
        check("timeout", 32'(timeout), 32'(e_to));
    endtask

    initial begin
        rst = 1'b1; req = '0; rr_en = 1'b0; done = 1'b0;
        m_busy = 0; m_owner = 0; m_held = 0; m_ptr = N - 1;

        // Reset state
        step(); step();
        check("rst_vld", 32'(gnt_vld), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        rst = 1'b0;

        // Fixed priority: 5 wins over 2, then 2 after a dead cycle
        req = 8'b0010_0101;
        step();
        check("fix_gnt5", 32'(gnt), 32'h20);
        check("fix_id5", 32'(gnt_id), 32'd5);
        step(); step();
        req = 8'b0000_0101;
        step();
        check("fix_dead", 32'(gnt_vld), 32'd0);
        step();
        check("fix_id2", 32'(gnt_id), 32'd2);
        req = '0;
        step(); step();

        // Round-robin rotation with done pulsed on every grant
        rr_en = 1'b1; req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            step();
            check("rr_id", 32'(gnt_id), 32'((7 - k + 8) % 8));
            done = 1'b1;
            step();
            check("rr_gap", 32'(gnt_vld), 32'd0);
            done = 1'b0;
        end
        req = '0;
        step(); step();

        // Hold budget expiry and re-grant
        rr_en = 1'b0; req = 8'h08;
        for (int k = 0; k < MAX_HOLD; k++) begin
            step();
            check("to_held", 32'(gnt_vld), 32'd1);
        end
        step();
        check("to_pulse", 32'(timeout), 32'd1);
        check("to_vld0", 32'(gnt_vld), 32'd0);
        step();
        check("to_regnt", 32'(gnt_id), 32'd3);
        check("to_clear", 32'(timeout), 32'd0);
        req = '0;
        step(); step();

        // No preemption by a higher index
        req = 8'h02;
        step();
        req = 8'h82;
        step();
        check("np_hold", 32'(gnt_id), 32'd1);
        step();
        req = 8'h80;
        step();
        check("np_rel", 32'(gnt_vld), 32'd0);
        step();
        check("np_id7", 32'(gnt_id), 32'd7);
        req = '0;
        step(); step();

        // Reset mid-grant, then rr pick from the restored pointer
        rr_en = 1'b1; req = 8'h40;
        step();
        check("mr_id6", 32'(gnt_id), 32'd6);
        rst = 1'b1;
        step();
        check("mr_vld", 32'(gnt_vld), 32'd0);
        check("mr_id0", 32'(gnt_id), 32'd0);
        rst = 1'b0; req = 8'h41;
        step();
        check("mr_rr6", 32'(gnt_id), 32'd6);
        req = '0;
        step(); step();

        // done plus req drop exactly at the budget limit
        rr_en = 1'b0; req = 8'h08;
        for (int k = 0; k < MAX_HOLD; k++) step();
        req = '0; done = 1'b1;
        step();
        check("dd_noto", 32'(timeout), 32'd0);
        check("dd_vld0", 32'(gnt_vld), 32'd0);
        req = 8'h08; done = 1'b0;
        step();
        check("dd_regnt", 32'(gnt_vld), 32'd1);
        req = '0;
        step(); step();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            req   = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            if ($urandom_range(0, 3) != 0) req = req | gnt;
            done  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) rr_en = ~rr_en;
            rst   = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prio_arbiter.md
Name: prio_arbiter

Overview:
- Sequential arbiter that shares one resource among N requesters, using highest-index-wins priority encoding as its selection core.
- Registers a single winner and holds the grant until the owner releases the resource or its hold budget expires.
- Two modes: fixed priority (index N-1 highest) and round-robin (rotating priority).
- Sits between requesting blocks and the shared resource; gnt_id drives the resource mux select.

Parameters:
- N, 8, number of requesters (2..32).
- ID_W, $clog2(N), width of gnt_id.
- MAX_HOLD, 16, max cycles a grant may stay asserted; 0 = unlimited.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  N  request vector, bit i = requester i
- rr_en  input  1  1 = round-robin, 0 = fixed priority; sampled only at arbitration
- done  input  1  owner releases the resource this cycle
- gnt  output  N  one-hot grant, all-zero when idle
- gnt_id  output  ID_W  index of granted requester, 0 when idle
- gnt_vld  output  1  a grant is active
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD

Behaviour:
- Reset:
  - gnt=0, gnt_id=0, gnt_vld=0, timeout=0.
  - State IDLE, hold counter 0, rr pointer ptr=N-1.
  - Reset mid-grant takes effect at the next edge, with no release cycle.
- Two states, IDLE and GRANT. All outputs are registered.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick winner w, then on the next edge: gnt[w]=1, gnt_id=w, gnt_vld=1, counter=1, go to GRANT.
  - Latency: 1 cycle from req visible to gnt.
- Fixed mode: w = highest set index of req.
- Round-robin mode:
  - Search downward from ptr, wrapping N-1 -> 0; w = first set bit found.
  - Implementation: masked pick over bits <= ptr; if that mask is empty, use the unmasked pick.
  - On grant, ptr <= (w==0) ? N-1 : w-1.
  - ptr is not updated in fixed mode.
- GRANT, release conditions (any one):
  - req[gnt_id]==0
  - done==1
  - MAX_HOLD!=0 and counter==MAX_HOLD with req still high and done low. This also pulses timeout=1 for one cycle, coincident with the first idle cycle.
- On release, the next edge clears gnt/gnt_id/gnt_vld and returns to IDLE.
- Every release is followed by one mandatory dead cycle in IDLE.
- Back-to-back grants are therefore spaced by at least one cycle with gnt_vld=0.
- While no release condition holds, the counter increments each cycle, saturating at MAX_HOLD.
- Simultaneous events:
  - done together with req drop: single release, no timeout.
  - done on the timeout cycle: timeout=0 (done wins).
- Requests arriving during GRANT are ignored until the next IDLE evaluation.
- A requester may not be preempted by a higher-priority one.
- rr_en may change at any time; it only affects the next IDLE decision.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_vld == |gnt.
  - gnt == (1<<gnt_id) when gnt_vld.

Decomposition:
- Package arb_pkg:
  - state enum {ST_IDLE, ST_GRANT}
  - default N / MAX_HOLD constants
  - function for the wrap-decrement of ptr
- Sub-module prio_pick:
  - Combinational: N-bit vector in, found + ID_W index out, highest set index wins.
  - Instantiated twice: masked and unmasked vector for round-robin; the unmasked instance also serves fixed mode.

Test Plan:
- Fixed mode, rr_en=0, req=8'b0010_0101 held -> gnt=8'b0010_0000, gnt_id=5 one cycle later. Drop req[5] -> one dead cycle, then gnt_id=2.
- Round-robin, rr_en=1, req=8'hFF held, done pulsed each grant -> gnt_id sequence 7,6,5,...,0,7, with gnt_vld=0 for one cycle between grants.
- Timeout, MAX_HOLD=4, req[3] held, done=0 -> gnt_vld high exactly 4 cycles, then timeout=1 for one cycle and gnt_vld=0. Re-grant to 3 follows if req[3] is still high.
- No preemption: grant to 1, then raise req[7] -> gnt stays at 1 until release; next grant goes to 7 (fixed mode).
- Reset mid-grant: rst=1 while gnt_id=6 -> next edge all outputs 0, ptr=7. After rst=0 with req=8'h41 in rr mode -> gnt_id=6.
- done and req drop on the same cycle at counter==MAX_HOLD -> single release, timeout stays 0, exactly one dead cycle.
